// File: rtl/multi_cycle_cpu.sv
// multi_cycle_cpu: RV64-subset multi-cycle core with imem/regfile/alu/dmem.
// Optional MULTI_CYCLE_CPU_INSTRET_EN adds a 64-bit retired-instruction counter.
package multi_cycle_cpu_pkg;
  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef struct packed {
    logic is_r;
    logic is_addi;
    logic is_ld;
    logic is_sd;
    logic is_beq;
    logic is_bne;
  } dec_t;
endpackage

module mcc_imem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   dout
);
  logic [31:0] mem [DEPTH];

  // program load port; read is asynchronous
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign dout = mem[addr];
endmodule

module mcc_regfile #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         we,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [4:0]   rd,
  input  logic [W-1:0] din,
  output logic [W-1:0] rs1_dout,
  output logic [W-1:0] rs2_dout
);
  logic [W-1:0] regs [32];

  // x0 is never written, so it always reads back zero
  always_ff @(posedge clk) begin
    if (we && rd != 5'd0) regs[rd] <= din;
  end

  assign rs1_dout = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_dout = (rs2 == 5'd0) ? '0 : regs[rs2];
endmodule

module mcc_alu #(
  parameter int W = 64
) (
  input  logic [3:0]   ctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         zero
);
  // four-function ALU; unknown codes fall back to add
  always_comb begin
    y = a + b;
    case (ctrl)
      4'b0110: y = a - b;
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      default: y = a + b;
    endcase
  end

  assign zero = (y == '0);
endmodule

module mcc_dmem #(
  parameter int W     = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);
  logic [W-1:0] mem [DEPTH];

  // one word per address, synchronous write
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = re ? mem[addr] : '0;
endmodule

module multi_cycle_cpu
  import multi_cycle_cpu_pkg::*;
#(
  parameter int IMEM_DEPTH      = 1024,
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int REG_WIDTH       = 64,
  parameter int DMEM_DEPTH      = 1024,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter logic [REG_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_b,
  output logic [REG_WIDTH-1:0] pc,
  output logic                 retire,
  output logic                 halted,
  output logic [63:0]          instret
);
  localparam int W = REG_WIDTH;

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] imm_q, imm_d;
  logic [W-1:0] aluout_q, aluout_d;
  logic [W-1:0] mdr_q, mdr_d;

  logic [31:0]  imem_dout;
  logic [W-1:0] rs1_dout, rs2_dout;
  logic [W-1:0] alu_b, alu_y;
  logic         alu_zero;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] dmem_dout;
  logic [W-1:0] rd_din;
  logic [W-1:0] imm;
  logic [W-1:0] pc_plus4, br_tgt;
  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
  logic [W-1:0] dmem_din;
  logic         mem_read, mem_write, reg_write;
  logic         retire_c, supported, is_br;
  dec_t         dec;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  // opcode/funct3 classification of the latched instruction
  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opc == OP_R):                     dec.is_r    = 1'b1;
      (opc == OP_ADDI && f3 == 3'b000):  dec.is_addi = 1'b1;
      (opc == OP_LD):                    dec.is_ld   = 1'b1;
      (opc == OP_SD):                    dec.is_sd   = 1'b1;
      (opc == OP_BR && f3 == 3'b000):    dec.is_beq  = 1'b1;
      (opc == OP_BR && f3 == 3'b001):    dec.is_bne  = 1'b1;
      default: ;
    endcase
  end

  assign supported = |dec;
  assign is_br     = dec.is_beq | dec.is_bne;

  // immediate selection: S for stores, B for branches, I otherwise
  always_comb begin
    imm = {{(W-12){ir_q[31]}}, ir_q[31:20]};
    unique case (1'b1)
      dec.is_sd:
        imm = {{(W-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      is_br:
        imm = {{(W-13){ir_q[31]}}, ir_q[31], ir_q[7],
               ir_q[30:25], ir_q[11:8], 1'b0};
      default: ;
    endcase
  end

  // ALU control: branches compare by subtraction, R-type by funct
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (1'b1)
      is_br:
        alu_ctrl = ALU_SUB;
      (dec.is_r && f3 == 3'b000 && f7 == 7'b0100000):
        alu_ctrl = ALU_SUB;
      (dec.is_r && f3 == 3'b111 && f7 == 7'b0000000):
        alu_ctrl = ALU_AND;
      (dec.is_r && f3 == 3'b110 && f7 == 7'b0000000):
        alu_ctrl = ALU_OR;
      default: ;
    endcase
  end

  assign alu_b    = (dec.is_r | is_br) ? b_q : imm_q;
  assign pc_plus4 = pc_q + W'(4);
  assign br_tgt   = pc_q + imm_q;

  // main FSM: next state, datapath latches and strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    retire_c  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    rd_din    = aluout_q;
    case (state_q)
      FETCH: begin
        ir_d    = imem_dout;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rs1_dout;
        b_d     = rs2_dout;
        imm_d   = imm;
        state_d = supported ? EXEC : HALT;
      end
      EXEC: begin
        aluout_d = alu_y;
        if (is_br) begin
          if (dec.is_beq ? alu_zero : !alu_zero)
            pc_d = br_tgt;
          else
            pc_d = pc_plus4;
          retire_c = 1'b1;
          state_d  = FETCH;
        end else if (dec.is_ld | dec.is_sd) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dec.is_ld) begin
          mem_read = 1'b1;
          mdr_d    = dmem_dout;
          state_d  = WB;
        end else begin
          mem_write = 1'b1;
          pc_d      = pc_plus4;
          retire_c  = 1'b1;
          state_d   = FETCH;
        end
      end
      WB: begin
        reg_write = 1'b1;
        rd_din    = dec.is_ld ? mdr_q : aluout_q;
        pc_d      = pc_plus4;
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // architectural and inter-step state
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
    end
  end

  assign dmem_addr = aluout_q[DMEM_ADDR_WIDTH-1:0];
  assign dmem_din  = b_q;

  mcc_imem #(.DEPTH(IMEM_DEPTH), .AW(IMEM_ADDR_WIDTH)) u_imem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (pc_q[IMEM_ADDR_WIDTH-1:0]),
    .dout  (imem_dout)
  );

  mcc_regfile #(.W(W)) u_rf (
    .clk      (clk),
    .we       (reg_write & reset_b),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd       (rd),
    .din      (rd_din),
    .rs1_dout (rs1_dout),
    .rs2_dout (rs2_dout)
  );

  mcc_alu #(.W(W)) u_alu (
    .ctrl (alu_ctrl),
    .a    (a_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  mcc_dmem #(
    .W(W), .DEPTH(DMEM_DEPTH), .AW(DMEM_ADDR_WIDTH)
  ) u_dmem (
    .clk  (clk),
    .we   (mem_write & reset_b),
    .re   (mem_read),
    .addr (dmem_addr),
    .din  (dmem_din),
    .dout (dmem_dout)
  );

  assign pc     = pc_q;
  assign retire = retire_c;
  assign halted = (state_q == HALT);

`ifdef MULTI_CYCLE_CPU_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // retired-instruction counter, wraps at 2^64
  always_comb begin
    instret_d = instret_q + {63'd0, retire_c};
  end

  // counter register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) instret_q <= '0;
    else          instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb_multi_cycle_cpu: directed and random programs checked
// against an instruction-level reference model.
module tb_multi_cycle_cpu;
  logic        clk;
  logic        reset_b;
  logic [63:0] pc;
  logic        retire;
  logic        halted;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  logic [31:0] prog [256];
  logic [63:0] m_x [32];
  bit          kn [32];
  logic [63:0] m_mem [1024];
  logic [63:0] m_pc;
  longint      n_ret;
  logic [9:0]  last_ma;
  logic [63:0] last_md;

  multi_cycle_cpu dut (
    .clk     (clk),
    .reset_b (reset_b),
    .pc      (pc),
    .retire  (retire),
    .halted  (halted),
    .instret (instret)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] e_r(int f7, int f3, int rd,
                                      int rs1, int rs2);
    logic [6:0] a; logic [2:0] b; logic [4:0] c, d, e;
    a = f7[6:0]; b = f3[2:0]; c = rd[4:0]; d = rs1[4:0]; e = rs2[4:0];
    return {a, e, d, b, c, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_i(int op, int f3, int rd,
                                      int rs1, int imm);
    logic [11:0] t; logic [6:0] o; logic [2:0] f; logic [4:0] c, d;
    t = imm[11:0]; o = op[6:0]; f = f3[2:0]; c = rd[4:0]; d = rs1[4:0];
    return {t, d, f, c, o};
  endfunction

  function automatic logic [31:0] e_addi(int rd, int rs1, int imm);
    return e_i(7'b0010011, 0, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] e_ld(int rd, int rs1, int imm);
    return e_i(7'b0000011, 3, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] e_sd(int rs2, int rs1, int imm);
    logic [11:0] t; logic [4:0] d, e;
    t = imm[11:0]; d = rs1[4:0]; e = rs2[4:0];
    return {t[11:5], e, d, 3'b011, t[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_br(int f3, int rs1, int rs2, int imm);
    logic [12:0] t; logic [2:0] f; logic [4:0] d, e;
    t = imm[12:0]; f = f3[2:0]; d = rs1[4:0]; e = rs2[4:0];
    return {t[12], t[10:5], e, d, f, t[4:1], t[11], 7'b1100011};
  endfunction

  function automatic logic [63:0] sx(logic [12:0] v, int bits);
    logic [63:0] r;
    r = {51'd0, v};
    if (v[bits-1]) r = r | ~((64'd1 << bits) - 64'd1);
    return r;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'd0;
  endtask

  task automatic set_reg(logic [4:0] rd, logic [63:0] v);
    if (rd != 0) begin
      m_x[rd] = v;
      kn[rd]  = 1;
    end
  endtask

  // ISA-level execution of one instruction of prog at m_pc
  task automatic model_step(output int lat, output int mw,
                            output int rw, output bit hlt,
                            output logic [9:0] sa,
                            output logic [63:0] sv);
    logic [31:0] w;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] a, b, v, ea;
    logic [12:0] i12, s12, b13;
    w   = prog[m_pc[9:2]];
    op  = w[6:0];   rd  = w[11:7];  f3 = w[14:12];
    rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
    a   = (rs1 == 0) ? 64'd0 : m_x[rs1];
    b   = (rs2 == 0) ? 64'd0 : m_x[rs2];
    i12 = {1'b0, w[31:20]};
    s12 = {1'b0, w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    lat = 0; mw = 0; rw = 0; hlt = 0; sa = 0; sv = 0;
    case (op)
      7'b0110011: begin
        if (f3 == 0 && f7 == 7'h20)     v = a - b;
        else if (f3 == 7 && f7 == 0)    v = a & b;
        else if (f3 == 6 && f7 == 0)    v = a | b;
        else                            v = a + b;
        set_reg(rd, v); lat = 4; rw = 1; m_pc = m_pc + 4;
      end
      7'b0010011: begin
        if (f3 != 0) hlt = 1;
        else begin
          set_reg(rd, a + sx(i12, 12)); lat = 4; rw = 1;
          m_pc = m_pc + 4;
        end
      end
      7'b0000011: begin
        ea = a + sx(i12, 12);
        set_reg(rd, m_mem[ea[9:0]]); lat = 5; rw = 1;
        m_pc = m_pc + 4;
      end
      7'b0100011: begin
        ea = a + sx(s12, 12);
        m_mem[ea[9:0]] = b; sa = ea[9:0]; sv = b;
        lat = 4; mw = 1; m_pc = m_pc + 4;
      end
      7'b1100011: begin
        if (f3 > 1) hlt = 1;
        else begin
          lat = 3;
          if ((f3 == 0) ? (a == b) : (a != b))
            m_pc = m_pc + sx(b13, 13);
          else
            m_pc = m_pc + 4;
        end
      end
      default: hlt = 1;
    endcase
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef MULTI_CYCLE_CPU_INSTRET_EN
    return n_ret;
`else
    return 64'd0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_b = 0;
    for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = 32'd0;
    for (int i = 0; i < 256; i++) dut.u_imem.mem[i*4] = prog[i];
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (pc !== 64'd0 || retire !== 0 || halted !== 0 ||
        instret !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%h retire=%b halted=%b instret=%0d want 0/0/0/0",
               pc, retire, halted, instret);
    end
    reset_b = 1;
    m_pc    = 64'd0;
    n_ret   = 0;
  endtask

  task automatic check_halt();
    logic [63:0] hp;
    int bad;
    hp = m_pc;
    #1;
    checks++;
    if (halted !== 0) begin
      errors++;
      $display("FAIL halt_early_c1: halted=%b want 0", halted);
    end
    @(negedge clk); #1;
    checks++;
    if (halted !== 0) begin
      errors++;
      $display("FAIL halt_early_c2: halted=%b want 0", halted);
    end
    @(negedge clk); #1;
    checks++;
    if (halted !== 1) begin
      errors++;
      $display("FAIL halt_set: halted=%b want 1", halted);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (dut.mem_write || dut.reg_write || retire ||
          pc !== hp || halted !== 1) bad++;
      @(negedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_quiet: %0d bad cycles pc=%h want 0 bad pc=%h",
               bad, pc, hp);
    end
  endtask

  // runs up to n instructions, checking each against the model
  task automatic run_prog(int n);
    int lat, mw, rw, cyc, mwc, rwc;
    bit hlt, got;
    logic [9:0]  sa, ma;
    logic [63:0] sv, md, pc0, pr;
    for (int k = 0; k < n; k++) begin
      pc0 = m_pc;
      model_step(lat, mw, rw, hlt, sa, sv);
      if (hlt) begin
        check_halt();
        return;
      end
      cyc = 0; mwc = 0; rwc = 0; got = 0; ma = 0; md = 0; pr = 0;
      while (cyc < 12) begin
        cyc++;
        #1;
        if (dut.mem_write) begin
          mwc++; ma = dut.dmem_addr; md = dut.dmem_din;
        end
        if (dut.reg_write) rwc++;
        if (retire) begin
          got = 1; pr = pc;
          break;
        end
        @(negedge clk);
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL retire_timeout: pc=%h no retire in %0d cycles", pc0, cyc);
        return;
      end
      n_ret++;
      checks++;
      if (cyc != lat) begin
        errors++;
        $display("FAIL latency: pc=%h got %0d want %0d", pc0, cyc, lat);
      end
      checks++;
      if (pr !== pc0) begin
        errors++;
        $display("FAIL pc_hold: got %h want %h", pr, pc0);
      end
      checks++;
      if (mwc != mw || rwc != rw) begin
        errors++;
        $display("FAIL strobes: pc=%h mw=%0d rw=%0d want %0d %0d",
                 pc0, mwc, rwc, mw, rw);
      end
      if (mw == 1) begin
        checks++;
        if (ma !== sa || md !== sv) begin
          errors++;
          $display("FAIL store: addr=%0d din=%h want %0d %h", ma, md, sa, sv);
        end
        last_ma = ma; last_md = md;
      end
      @(negedge clk); #1;
      checks++;
      if (pc !== m_pc) begin
        errors++;
        $display("FAIL next_pc: got %h want %h", pc, m_pc);
      end
      checks++;
      if (instret !== exp_instret()) begin
        errors++;
        $display("FAIL instret: got %0d want %0d", instret, exp_instret());
      end
    end
  endtask

  task automatic check_regs(string nm);
    for (int i = 1; i < 32; i++) begin
      if (kn[i]) begin
        checks++;
        if (dut.u_rf.regs[i] !== m_x[i]) begin
          errors++;
          $display("FAIL %s_x%0d: got %h want %h", nm, i,
                   dut.u_rf.regs[i], m_x[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = e_r(0, 0, 5, 0, 0);
    do_reset();
    run_prog(2);
  endtask

  task automatic test_arith();
    logic [63:0] want [8];
    clear_prog();
    prog[0] = e_addi(1, 0, 5);
    prog[1] = e_addi(2, 0, 3);
    prog[2] = e_r(0, 0, 3, 1, 2);
    prog[3] = e_r(7'h20, 0, 4, 1, 2);
    prog[4] = e_r(0, 7, 5, 1, 2);
    prog[5] = e_r(0, 6, 6, 1, 2);
    prog[6] = e_addi(7, 1, -1);
    do_reset();
    run_prog(8);
    want[3] = 8; want[4] = 2; want[5] = 1; want[6] = 7; want[7] = 4;
    for (int i = 3; i < 8; i++) begin
      checks++;
      if (dut.u_rf.regs[i] !== want[i]) begin
        errors++;
        $display("FAIL arith_x%0d: got %h want %h", i,
                 dut.u_rf.regs[i], want[i]);
      end
    end
  endtask

  task automatic test_memory();
    clear_prog();
    prog[0] = e_addi(1, 0, 16);
    prog[1] = e_addi(2, 0, 1781);
    for (int i = 0; i < 5; i++) prog[2+i] = e_r(0, 0, 2, 2, 2);
    prog[7] = e_addi(2, 2, 13);
    prog[8] = e_sd(2, 1, 8);
    prog[9] = e_ld(3, 1, 8);
    do_reset();
    run_prog(11);
    checks++;
    if (last_ma !== 10'd24 || last_md !== 64'hDEAD) begin
      errors++;
      $display("FAIL mem_sd: addr=%0d din=%h want 24 dead", last_ma, last_md);
    end
    checks++;
    if (dut.u_rf.regs[3] !== 64'hDEAD) begin
      errors++;
      $display("FAIL mem_ld: x3=%h want dead", dut.u_rf.regs[3]);
    end
  endtask

  task automatic test_branch();
    clear_prog();
    prog[0] = e_addi(1, 0, 1);
    prog[1] = e_addi(2, 0, 2);
    prog[2] = e_br(1, 1, 2, 8);
    prog[3] = e_addi(3, 0, 9);
    prog[4] = e_br(0, 1, 1, -8);
    do_reset();
    run_prog(4);
    checks++;
    if (pc !== 64'h8) begin
      errors++;
      $display("FAIL beq_back: pc=%h want 8", pc);
    end
    clear_prog();
    for (int i = 0; i < 4; i++) prog[i] = e_addi(1, 0, 1);
    prog[4] = e_br(1, 1, 1, 12);
    do_reset();
    run_prog(5);
    checks++;
    if (pc !== 64'h14) begin
      errors++;
      $display("FAIL bne_fall: pc=%h want 14", pc);
    end
  endtask

  task automatic test_self_loop();
    clear_prog();
    prog[0] = e_br(0, 0, 0, 0);
    do_reset();
    run_prog(5);
  endtask

  task automatic test_halt();
    clear_prog();
    for (int i = 0; i < 8; i++) prog[i] = e_addi(9, 9, 1);
    prog[8] = 32'h0000007F;
    do_reset();
    run_prog(20);
    checks++;
    if (pc !== 64'h20) begin
      errors++;
      $display("FAIL halt_pc: pc=%h want 20", pc);
    end
    reset_b = 0;
    #1;
    checks++;
    if (halted !== 0 || pc !== 64'd0) begin
      errors++;
      $display("FAIL halt_clear: halted=%b pc=%h want 0 0", halted, pc);
    end
    clear_prog();
    prog[0] = e_br(2, 0, 0, 8);
    do_reset();
    run_prog(2);
    clear_prog();
    prog[0] = e_i(7'b0010011, 1, 4, 0, 3);
    do_reset();
    run_prog(2);
  endtask

  task automatic test_midreset();
    clear_prog();
    prog[0] = e_addi(1, 0, 16);
    prog[1] = e_addi(2, 0, 7);
    prog[2] = e_sd(2, 1, 0);
    prog[3] = e_addi(2, 0, 99);
    prog[4] = e_sd(2, 1, 0);
    do_reset();
    run_prog(4);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dut.mem_write !== 1) begin
      errors++;
      $display("FAIL midrst_in_mem: mem_write=%b want 1", dut.mem_write);
    end
    reset_b = 0;
    #1;
    checks++;
    if (dut.mem_write !== 0 || pc !== 64'd0 || retire !== 0 ||
        halted !== 0 || instret !== 64'd0) begin
      errors++;
      $display("FAIL midrst_state: mw=%b pc=%h ret=%b hlt=%b ir=%0d want 0",
               dut.mem_write, pc, retire, halted, instret);
    end
    @(negedge clk); #1;
    checks++;
    if (dut.u_dmem.mem[16] !== m_mem[16]) begin
      errors++;
      $display("FAIL midrst_nowrite: mem16=%h want %h",
               dut.u_dmem.mem[16], m_mem[16]);
    end
    reset_b = 1;
    m_pc = 0;
    n_ret = 0;
  endtask

  task automatic test_random();
    int n, kind, f3, f7, a;
    int pool [8];
    clear_prog();
    n = 0;
    for (int r = 1; r < 32; r++)
      prog[n++] = e_addi(r, 0, int'($urandom_range(0, 4095)) - 2048);
    for (int i = 0; i < 8; i++) begin
      pool[i] = 256 + 8 * i;
      prog[n++] = e_sd($urandom_range(1, 31), 0, pool[i]);
    end
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 31);
      if (kind < 4) begin
        f3 = $urandom_range(0, 7);
        case ($urandom_range(0, 2))
          0: f7 = 0;
          1: f7 = 7'h20;
          default: f7 = $urandom_range(0, 127);
        endcase
        if ($urandom_range(0, 1) == 1) f3 = (f3 < 4) ? 0 : 6 + (f3 & 1);
        prog[n++] = e_r(f7, f3, a, $urandom_range(0, 31),
                        $urandom_range(0, 31));
      end else if (kind < 6) begin
        prog[n++] = e_addi(a, $urandom_range(0, 31),
                           int'($urandom_range(0, 4095)) - 2048);
      end else if (kind == 6) begin
        prog[n++] = e_sd($urandom_range(0, 31), 0,
                         pool[$urandom_range(0, 7)]);
      end else if (kind == 7) begin
        prog[n++] = e_ld(a, 0, pool[$urandom_range(0, 7)]);
      end else begin
        f3 = $urandom_range(0, 1);
        prog[n++] = e_br(f3, a,
                         ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 31),
                         4 * $urandom_range(1, 3));
      end
    end
    do_reset();
    run_prog(200);
    check_regs("rand");
  endtask

  initial begin
    reset_b = 0;
    m_pc = 0;
    n_ret = 0;
    last_ma = 0;
    last_md = 0;
    for (int i = 0; i < 32; i++) begin
      m_x[i] = 0;
      kn[i]  = 0;
    end
    for (int i = 0; i < 1024; i++) m_mem[i] = 0;
    test_reset();
    test_arith();
    test_memory();
    test_branch();
    test_self_loop();
    test_halt();
    test_midreset();
    test_random();
    check_regs("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_cycle_cpu.md
# multi_cycle_cpu

Multi-cycle RV64 subset CPU: one instruction executes over 3–5 clock cycles under a main FSM, with architectural state latched between steps (IR, A, B, ALUOut, MDR). It is the successor to the single-cycle core and reuses the existing imem, regfile, alu and dmem datapath modules. Compared with the single-cycle core it adds a parametrised word width, addi/bne support, a halt state for unsupported opcodes, and retire/observability outputs.

## Interface
- IMEM_DEPTH, 1024, imem entries
- IMEM_ADDR_WIDTH, 10, imem address bits
- REG_WIDTH, 64, register, ALU and PC width
- DMEM_DEPTH, 1024, dmem entries
- DMEM_ADDR_WIDTH, 10, dmem address bits
- RESET_PC, 0, PC value loaded on reset
- clk  input  1  system clock; all state updates on the rising edge
- reset_b  input  1  reset, asynchronous and active-low
- pc  output  REG_WIDTH  architectural PC; reset value RESET_PC
- retire  output  1  one-cycle pulse on the final cycle of each instruction; reset 0
- halted  output  1  high once an unsupported opcode is decoded; reset 0
- instret  output  64  count of retired instructions; reset 0

## Operation
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is FETCH.
- FETCH:
  - IR <= imem dout at address pc[IMEM_ADDR_WIDTH-1:0].
  - Next state is DECODE.
- DECODE:
  - A <= rs1_dout, B <= rs2_dout, IMM <= sign-extended immediate.
  - Immediate formats: I-type for ld/addi, S-type for sd, B-type (LSB 0) for beq/bne.
  - Unsupported opcode -> HALT.
- EXEC:
  - ALUOut <= alu(A, B or IMM).
  - ALU control codes: add 0010, sub 0110, and 0000, or 0001.
  - R-type decodes funct3/funct7: add, sub, and, or. Any other R-type encoding -> add.
  - ld/sd/addi use add; beq/bne use sub.
  - Branch: pc <= pc + IMM when taken (beq: zero=1; bne: zero=0), otherwise pc + 4. Assert retire; next state is FETCH.
  - ld/sd -> MEM. R-type/addi -> WB.
- MEM:
  - ld: mem_read=1, MDR <= dmem dout, next state WB.
  - sd: mem_write=1 with din = B for exactly this cycle; pc <= pc + 4; retire; next state FETCH.
- WB:
  - reg_write=1; rd_din = MDR for ld, ALUOut otherwise.
  - pc <= pc + 4; retire; next state FETCH.
  - Writes to x0 have no effect (regfile behaviour).
- HALT:
  - Absorbing state: no memory or register writes; pc frozen; halted=1.
  - Only reset exits HALT.
- mem_read, mem_write and reg_write are low in every state except where stated above.
- All PC arithmetic is REG_WIDTH bits, modulo 2^REG_WIDTH.
- Supported opcodes: 0110011 R, 0010011 addi (funct3 000 only), 0000011 ld, 0100011 sd, 1100011 beq (funct3 000) / bne (funct3 001).
  - Any other funct3 under opcode 1100011 or 0010011 is unsupported -> HALT.

## Timing
- Latency in cycles: beq/bne 3, R-type/addi 4, sd 4, ld 5.
- pc changes only on the retire cycle's clock edge; within an instruction, pc holds the address of the executing instruction.
- retire is high for exactly one cycle per instruction, coincident with the pc update. instret increments on that same edge.
- Reset assertion mid-instruction (any state):
  - Immediately forces FETCH, pc=RESET_PC, retire=0, halted=0, instret=0.
  - A pending sd write or WB write in that cycle is suppressed.
- Register read-after-write: WB writes the regfile at its clock edge. The next instruction reads the regfile in DECODE, two cycles later, so no forwarding is needed.
- A branch to its own address loops indefinitely with retire pulsing every 3 cycles.

## Configuration
- MULTI_CYCLE_CPU_INSTRET_EN
  - Defined: 64-bit instret counter implemented, incrementing on each retire and wrapping at 2^64.
  - Undefined: no counter flops are instantiated and instret is tied to 0.
- retire is present in both builds.

## Test plan
- Reset: hold reset_b low 3 cycles with RESET_PC=0 -> pc=0, retire=0, halted=0, instret=0. First retire occurs 4 cycles after release, for an R-type at address 0.
- Arithmetic: with x1=5 and x2=3 preloaded, run add x3,x1,x2; sub x4,x1,x2; and x5; or x6; addi x7,x1,-1 -> x3=8, x4=2, x5=1, x6=7, x7=4. Retires occur at 4-cycle spacing.
- Memory: x1=16, x2=0xDEAD; sd x2,8(x1) then ld x3,8(x1) -> mem_write pulses exactly 1 cycle at dmem address 24 with din=0xDEAD; x3=0xDEAD; ld spans 5 cycles.
- Branches: beq x1,x1,-8 at pc=0x10 -> pc=0x8 after 3 cycles. bne x1,x1,+12 -> pc=0x14. Branches never assert reg_write or mem_write.
- Halt: opcode 1111111 at pc=0x20 -> halted=1 two cycles after fetch, pc stays 0x20, no writes for 20 cycles. Asserting reset_b low then clears halted.
- Mid-instruction reset: assert reset_b during the MEM cycle of an sd -> no memory write, pc=RESET_PC, and, with MULTI_CYCLE_CPU_INSTRET_EN defined, instret=0.
